// File: rtl/inst_prefetch_decode.sv
// Thumb prefetch/decode front end: word fetch, halfword queue, 16/32-bit assembly.
// Optional perf counters are enabled with `define INST_PREFETCH_PERF_EN.
module inst_prefetch_decode #(
    parameter int unsigned       QDEPTH   = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic [31:0]       fetch_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic              out_is32,
    output logic [ADDR_W-1:0] out_pc
`ifdef INST_PREFETCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned PW    = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(QDEPTH);
    localparam logic [PW:0] ONE   = (PW+1)'(1);
    localparam logic [PW:0] TWO   = (PW+1)'(2);

    typedef enum logic [1:0] {BOOT, RUN, REDIR} state_t;

    state_t            state, state_next;
    logic [15:0]       mem [QDEPTH];
    logic [PW-1:0]     rptr, wptr, rptr_nx1, wptr_nx1;
    logic [PW:0]       count, free, push_n, pop_n, avail_n, need;
    logic [ADDR_W-1:0] fpc, dpc, redir_pc;
    logic [15:0]       in_lo, in_hi, hw0, hw1;
    logic              take, is32, load;

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            REDIR:   state_next = RUN;
            default: state_next = RUN;
        endcase
        if (flush) state_next = REDIR;
    end

    assign free       = DEPTH - count;
    assign fetch_req  = !rst && (state == RUN) && (free >= TWO);
    assign fetch_addr = fpc & ~ADDR_W'(3);
    assign take       = fetch_req && fetch_ack && !flush;

    // An odd-halfword fetch address keeps only the upper half of the word.
    assign in_lo  = fpc[1] ? fetch_data[31:16] : fetch_data[15:0];
    assign in_hi  = fetch_data[31:16];
    assign push_n = !take ? '0 : (fpc[1] ? ONE : TWO);

    assign rptr_nx1 = rptr + PW'(1);
    assign wptr_nx1 = wptr + PW'(1);

    // Incoming halfwords are visible to the assembler in the ack cycle, so an
    // empty pipe produces an instruction the cycle after the ack.
    assign avail_n = count + push_n;
    assign hw0 = (count != '0) ? mem[rptr] : in_lo;
    assign hw1 = (count >= TWO) ? mem[rptr_nx1] : ((count == ONE) ? in_lo : in_hi);

    assign is32  = (hw0[15:13] == 3'b111) && (hw0[12:11] != 2'b00);
    assign need  = is32 ? TWO : ONE;
    assign load  = (state == RUN) && !flush && (!out_valid || out_ready) && (avail_n >= need);
    assign pop_n = load ? need : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + push_n[PW-1:0];
            rptr  <= rptr + pop_n[PW-1:0];
            count <= count + push_n - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != '0) begin
            mem[wptr] <= in_lo;
            if (push_n == TWO) mem[wptr_nx1] <= in_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc      <= '0;
            dpc      <= '0;
            redir_pc <= '0;
        end else begin
            if (flush) redir_pc <= flush_addr & ~ADDR_W'(1);
            case (state)
                BOOT: begin
                    fpc <= RESET_PC & ~ADDR_W'(1);
                    dpc <= RESET_PC & ~ADDR_W'(1);
                end
                REDIR: begin
                    fpc <= redir_pc;
                    dpc <= redir_pc;
                end
                default: begin
                    if (take) fpc <= (fpc & ~ADDR_W'(3)) + ADDR_W'(4);
                    if (load) dpc <= dpc + (is32 ? ADDR_W'(4) : ADDR_W'(2));
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ir    <= '0;
            out_is32  <= 1'b0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_ir    <= is32 ? {hw0, hw1} : {16'h0000, hw0};
            out_is32  <= is32;
            out_pc    <= dpc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef INST_PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if ((state == RUN) && !out_valid && (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_decode.sv
// Directed bench for inst_prefetch_decode: length-decode table plus multi-cycle sequences.
module tb_inst_prefetch_decode;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_addr;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic        out_is32;
    logic [31:0] out_pc;
`ifdef INST_PREFETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    inst_prefetch_decode #(
        .QDEPTH  (4),
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .flush_addr(flush_addr),
        .fetch_req (fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_ack (fetch_ack),
        .fetch_data(fetch_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_is32  (out_is32),
        .out_pc    (out_pc)
`ifdef INST_PREFETCH_PERF_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word0;
        logic [31:0] word1;
        logic [31:0] exp_ir;
        logic        exp_is32;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] imem [64];
    bit          auto_ack;
    int          compared;
    int          mismatched;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            fetch_ack  = fetch_req;
            fetch_data = imem[fetch_addr[7:2]];
        end else begin
            fetch_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        fetch_ack = 1'b0;
        out_ready = 1'b0;
        auto_ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;

        vecs[0] = '{32'hAAAA_07FF, 32'h0, 32'h0000_07FF, 1'b0};
        vecs[1] = '{32'h1234_E7FF, 32'h0, 32'h0000_E7FF, 1'b0};
        vecs[2] = '{32'hE800_1234 & 32'h0 | 32'h1234_E800, 32'h0, 32'hE800_1234, 1'b1};
        vecs[3] = '{32'h5678_F000, 32'h0, 32'hF000_5678, 1'b1};
        vecs[4] = '{32'h9ABC_FFFF, 32'h0, 32'hFFFF_9ABC, 1'b1};
        vecs[5] = '{32'h0001_DFFF, 32'h0, 32'h0000_DFFF, 1'b0};

        compared   = 0;
        mismatched = 0;
        flush_addr = '0;
        fetch_data = '0;
        for (int k = 0; k < 64; k++)
            imem[k] = {16'(32'h101 + 2 * k), 16'(32'h100 + 2 * k)};

        // Reset values, then first request on the 2nd cycle after release.
        rst = 1'b1; flush = 1'b0; fetch_ack = 1'b0; out_ready = 1'b0; auto_ack = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ir", out_ir, 32'd0);
        chk("rst_out_is32", 32'(out_is32), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
`ifdef INST_PREFETCH_PERF_EN
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
        chk("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        rst = 1'b0;
        chk("boot_fetch_req", 32'(fetch_req), 32'd0);
        step();
        chk("run_fetch_req", 32'(fetch_req), 32'd1);
        chk("run_fetch_addr", fetch_addr, 32'h0);

        // Two 16-bit instructions from one word, with ack-to-output latency of one.
        out_ready  = 1'b1;
        fetch_ack  = 1'b1;
        fetch_data = 32'h1C4A_2001;
        step();
        chk("mix_valid0", 32'(out_valid), 32'd1);
        chk("mix_ir0", out_ir, 32'h0000_2001);
        chk("mix_pc0", out_pc, 32'h0);
        chk("mix_is32_0", 32'(out_is32), 32'd0);
        step();
        chk("mix_valid1", 32'(out_valid), 32'd1);
        chk("mix_ir1", out_ir, 32'h0000_1C4A);
        chk("mix_pc1", out_pc, 32'h2);
        chk("mix_is32_1", 32'(out_is32), 32'd0);
        step();
        chk("mix_drained", 32'(out_valid), 32'd0);
        chk("mix_next_addr", fetch_addr, 32'h4);

        // Length-decode table: first instruction at address 0.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            fetch_ack  = 1'b1;
            fetch_data = vecs[v].word0;
            step();
            fetch_ack  = fetch_req;
            fetch_data = vecs[v].word1;
            step();
            chk($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_ir", v), out_ir, vecs[v].exp_ir);
            chk($sformatf("tbl%0d_is32", v), 32'(out_is32), 32'(vecs[v].exp_is32));
            chk($sformatf("tbl%0d_pc", v), out_pc, 32'h0);
        end

        // 32-bit instruction split across two words.
        do_reset();
        out_ready  = 1'b1;
        fetch_ack  = 1'b1;
        fetch_data = 32'hF000_2001;
        step();
        chk("split_ir0", out_ir, 32'h0000_2001);
        chk("split_pc0", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("split_wait%0d", i), 32'(out_valid), 32'd0);
        end
        chk("split_addr1", fetch_addr, 32'h4);
        fetch_ack  = fetch_req;
        fetch_data = 32'h0000_F800;
        step();
        chk("split_valid1", 32'(out_valid), 32'd1);
        chk("split_ir1", out_ir, 32'hF000_F800);
        chk("split_is32_1", 32'(out_is32), 32'd1);
        chk("split_pc1", out_pc, 32'h2);
        step();
        chk("split_ir2", out_ir, 32'h0000_0000);
        chk("split_pc2", out_pc, 32'h6);

        // Backpressure, then an in-order drain of 20 instructions across pointer wrap.
        do_reset();
        auto_ack   = 1'b1;
        fetch_ack  = fetch_req;
        fetch_data = imem[0];
        step();
        chk("bp_first_ir", out_ir, 32'h0000_0100);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_hold_ir%0d", i), out_ir, 32'h0000_0100);
            chk($sformatf("bp_hold_pc%0d", i), out_pc, 32'h0);
            chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_req_low%0d", i), 32'(fetch_req), 32'd0);
        end
        out_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 20 && cyc < 200) begin
            if (out_valid) begin
                chk($sformatf("drain_ir%0d", n), out_ir, 32'(32'h100 + n));
                chk($sformatf("drain_pc%0d", n), out_pc, 32'(2 * n));
                n++;
            end
            step();
            cyc++;
        end
        chk("drain_count", 32'(n), 32'd20);

        // Flush to an odd-halfword target while a fetch is outstanding.
        do_reset();
        chk("uf_req_pending", 32'(fetch_req), 32'd1);
        flush      = 1'b1;
        flush_addr = 32'h0000_0103;
        step();
        flush = 1'b0;
        chk("uf_req_redir", 32'(fetch_req), 32'd0);
        chk("uf_valid_redir", 32'(out_valid), 32'd0);
        step();
        chk("uf_req_run", 32'(fetch_req), 32'd1);
        chk("uf_addr", fetch_addr, 32'h100);
        fetch_ack  = 1'b1;
        fetch_data = 32'hBF00_4770;
        step();
        chk("uf_valid", 32'(out_valid), 32'd1);
        chk("uf_ir", out_ir, 32'h0000_BF00);
        chk("uf_pc", out_pc, 32'h102);
        out_ready = 1'b1;
        step();
        chk("uf_single_push", 32'(out_valid), 32'd0);
        chk("uf_next_addr", fetch_addr, 32'h104);

        // Flush coinciding with ack: the acked word must never surface.
        do_reset();
        out_ready  = 1'b1;
        fetch_ack  = 1'b1;
        fetch_data = 32'h1111_2222;
        flush      = 1'b1;
        flush_addr = 32'h0000_0040;
        step();
        flush = 1'b0;
        chk("col_valid", 32'(out_valid), 32'd0);
        chk("col_req", 32'(fetch_req), 32'd0);
        step();
        chk("col_addr", fetch_addr, 32'h40);
        fetch_ack  = 1'b1;
        fetch_data = 32'h4444_3333;
        step();
        chk("col_ir", out_ir, 32'h0000_3333);
        chk("col_pc", out_pc, 32'h40);
`ifdef INST_PREFETCH_PERF_EN
        chk("col_perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
